// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter between two byte sources
//
// Purpose: grants the UART transmit path to one of two requesters using a
// valid/ready handshake. It drives the transmitter data bus and a strobe
// (the transmitter starts on the strobe's falling edge), then uses the
// transmitter's busy flag to track the frame until the line is free again.
//
// Ports:
//   clk, rst_n              clock and asynchronous active-low reset
//   req0_data/valid/ready   requester 0 byte handshake
//   req1_data/valid/ready   requester 1 byte handshake
//   tx_data, tx_int         byte and start strobe to the transmitter
//   tx_busy                 transmitter busy (frame on the line)
//   grant                   one-hot owner of the byte in flight, 00 when idle
//   err_timeout             one-cycle pulse when the transmitter never went busy
module uart_tx_arbiter #(
  parameter int INT_CYCLES    = 4,
  parameter int START_TIMEOUT = 64,
  parameter int GAP_CYCLES    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req0_data,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req1_data,
  input  logic       req1_valid,
  output logic       req1_ready,
  output logic [7:0] tx_data,
  output logic       tx_int,
  input  logic       tx_busy,
  output logic [1:0] grant,
  output logic       err_timeout
);

  localparam int MAXP = (INT_CYCLES > START_TIMEOUT)
                      ? ((INT_CYCLES > GAP_CYCLES) ? INT_CYCLES : GAP_CYCLES)
                      : ((START_TIMEOUT > GAP_CYCLES) ? START_TIMEOUT : GAP_CYCLES);
  localparam int CW = $clog2(MAXP) + 1;

  localparam logic [CW-1:0] INT_LAST  = CW'(INT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(START_TIMEOUT - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] CNT_LIMIT = CW'(MAXP);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STROBE,
    S_WAIT_START,
    S_WAIT_DONE,
    S_SETTLE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_int_q, tx_int_d;
  logic [1:0]    grant_q, grant_d;
  logic          err_q, err_d;
  logic          ptr_q, ptr_d;      // index of the requester served last

  logic          can_grant;
  logic          pick1;             // requester 1 wins this cycle's arbitration
  logic [CW-1:0] cnt_inc;           // saturating increment of the state counter

  always_comb begin
    can_grant = (state_q == S_IDLE) && !tx_busy;
    // On a tie the requester that was not served last wins.
    pick1      = req1_valid && (!req0_valid || !ptr_q);
    req0_ready = can_grant && req0_valid && !pick1;
    req1_ready = can_grant && pick1;
    cnt_inc    = (cnt_q == CNT_LIMIT) ? cnt_q : cnt_q + 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;
    tx_int_d  = tx_int_q;
    grant_d   = grant_q;
    err_d     = 1'b0;
    ptr_d     = ptr_q;
    case (state_q)
      S_IDLE: begin
        if (req0_ready || req1_ready) begin
          tx_data_d = pick1 ? req1_data : req0_data;
          grant_d   = pick1 ? 2'b10 : 2'b01;
          ptr_d     = pick1;
          tx_int_d  = 1'b1;
          cnt_d     = '0;
          state_d   = S_STROBE;
        end
      end
      S_STROBE: begin
        if (cnt_q == INT_LAST) begin
          tx_int_d = 1'b0;
          cnt_d    = '0;
          state_d  = S_WAIT_START;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_WAIT_START: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == TO_LAST) begin
          // Transmitter never started: drop the byte, it is not retried.
          err_d   = 1'b1;
          grant_d = 2'b00;
          cnt_d   = '0;
          state_d = S_SETTLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          cnt_d   = '0;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == GAP_LAST) begin
          grant_d = 2'b00;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d  = S_IDLE;
        tx_int_d = 1'b0;
        grant_d  = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      tx_data_q <= 8'h00;
      tx_int_q  <= 1'b0;
      grant_q   <= 2'b00;
      err_q     <= 1'b0;
      ptr_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tx_data_q <= tx_data_d;
      tx_int_q  <= tx_int_d;
      grant_q   <= grant_d;
      err_q     <= err_d;
      ptr_q     <= ptr_d;
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_int      = tx_int_q;
  assign grant       = grant_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter with a behavioural uart_tx and line receiver
module tb_uart_tx_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] req0_data, req1_data;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [7:0] tx_data;
  logic       tx_int;
  logic       tx_busy;
  logic [1:0] grant;
  logic       err_timeout;

  int errors = 0;
  int checks = 0;

  uart_tx_arbiter #(.INT_CYCLES(4), .START_TIMEOUT(64), .GAP_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_data(req0_data), .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req1_data(req1_data), .req1_valid(req1_valid), .req1_ready(req1_ready),
    .tx_data(tx_data), .tx_int(tx_int), .tx_busy(tx_busy),
    .grant(grant), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transmitter model: 0 = normal uart_tx, 1 = stubbed (never busy), 2 = busy forced by bench.
  int         mode = 0;
  logic       force_busy = 1'b0;
  logic       int_d1, busy_m;
  logic [9:0] sh;
  logic [1:0] div;
  logic [3:0] bitn;
  logic       line;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_d1 <= 1'b0; busy_m <= 1'b0; sh <= 10'h3FF; div <= 2'd0; bitn <= 4'd0;
    end else begin
      int_d1 <= tx_int;
      if (!busy_m) begin
        if (int_d1 && !tx_int && mode == 0) begin
          sh <= {1'b1, tx_data, 1'b0}; busy_m <= 1'b1; div <= 2'd0; bitn <= 4'd0;
        end
      end else if (div == 2'd3) begin
        div <= 2'd0;
        sh  <= {1'b1, sh[9:1]};
        if (bitn == 4'd9) busy_m <= 1'b0;
        else bitn <= bitn + 4'd1;
      end else begin
        div <= div + 2'd1;
      end
    end
  end

  assign line    = busy_m ? sh[0] : 1'b1;
  assign tx_busy = (mode == 2) ? force_busy : (mode == 0 && busy_m);

  // Serial receiver: 4 clocks per bit, samples mid-bit, publishes each decoded frame.
  logic       rx_act;
  int         rx_cnt;
  logic [7:0] rx_sh, rx_last;
  logic       rx_stop;
  int         rx_count = 0;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_act <= 1'b0; rx_cnt <= 0;
    end else if (!rx_act) begin
      if (!line) begin rx_act <= 1'b1; rx_cnt <= 1; end
    end else begin
      rx_cnt <= rx_cnt + 1;
      if (rx_cnt % 4 == 2) begin
        if (rx_cnt / 4 >= 1 && rx_cnt / 4 <= 8) rx_sh[rx_cnt / 4 - 1] <= line;
        if (rx_cnt / 4 == 9) begin
          rx_last <= rx_sh; rx_stop <= line; rx_count <= rx_count + 1; rx_act <= 1'b0;
        end
      end
    end
  end

  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one request, check the handshake/grant/strobe; with full=1 also follow the
  // frame to completion and compare the byte seen on the serial line.
  task automatic serve(input logic v0, input logic [7:0] d0, input logic v1, input logic [7:0] d1,
                       input logic er0, input logic er1, input logic [1:0] eg, input logic [7:0] eb,
                       input bit full);
    int n;
    int start_cnt;
    @(negedge clk);
    req0_valid = v0; req0_data = d0; req1_valid = v1; req1_data = d1;
    #1;
    n = 0;
    while (!(req0_ready || req1_ready) && n < 500) begin @(negedge clk); #1; n++; end
    chk("handshake_seen", (n < 500), 1);
    chk("ready_pair", {req0_ready, req1_ready}, {er0, er1});
    start_cnt = rx_count;
    cyc(1);
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = 8'hEE; req1_data = 8'hEE;
    chk("grant", grant, eg);
    chk("tx_data", tx_data, eb);
    n = 1;
    while (n < 100) begin
      cyc(1);
      if (!tx_int) break;
      n++;
    end
    chk("tx_int_high_cycles", n, 4);
    if (full) begin
      exp_q.push_back(eb);
      n = 0;
      while (!tx_busy && n < 200) begin cyc(1); n++; end
      while (tx_busy && n < 200) begin cyc(1); n++; end
      chk("frame_done_in_time", (n < 200), 1);
      chk("tx_data_held", tx_data, eb);
      cyc(2);
      chk("grant_held_in_gap", grant, eg);
      cyc(1);
      chk("grant_idle_after_gap", grant, 2'b00);
      n = 0;
      while (rx_count == start_cnt && n < 50) begin cyc(1); n++; end
      if (rx_count == start_cnt || exp_q.size() == 0) begin
        chk("frame_received", 0, 1);
      end else begin
        chk("line_byte", rx_last, exp_q.pop_front());
        chk("line_stop_bit", rx_stop, 1);
      end
    end
  endtask

  typedef struct {
    logic       v0;
    logic [7:0] d0;
    logic       v1;
    logic [7:0] d1;
    logic       r0;
    logic       r1;
    logic [1:0] g;
    logic [7:0] b;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int n;
    vecs[0] = '{1'b1, 8'hA5, 1'b0, 8'h00, 1'b1, 1'b0, 2'b01, 8'hA5};
    vecs[1] = '{1'b0, 8'h00, 1'b1, 8'h5A, 1'b0, 1'b1, 2'b10, 8'h5A};
    vecs[2] = '{1'b0, 8'h00, 1'b1, 8'hC3, 1'b0, 1'b1, 2'b10, 8'hC3};
    vecs[3] = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b0, 2'b01, 8'h11};
    vecs[4] = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 1'b1, 2'b10, 8'h22};
    vecs[5] = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b0, 2'b01, 8'h11};
    vecs[6] = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 1'b1, 2'b10, 8'h22};

    req0_valid = 1'b1; req1_valid = 1'b1; req0_data = 8'h00; req1_data = 8'h00;
    rst_n = 1'b0;
    #1;
    chk("rst_grant", grant, 2'b00);
    chk("rst_tx_int", tx_int, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_err", err_timeout, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    chk("rst_readys", {req0_ready, req1_ready}, 2'b00);
    cyc(3);
    rst_n = 1'b1;
    cyc(2);

    // Single requester, lone requester 1 twice, then alternating ties.
    for (int i = 0; i < 7; i++)
      serve(vecs[i].v0, vecs[i].d0, vecs[i].v1, vecs[i].d1,
            vecs[i].r0, vecs[i].r1, vecs[i].g, vecs[i].b, 1'b1);

    // Stubbed transmitter: timeout 64 cycles after the strobe falls.
    mode = 1;
    serve(1'b1, 8'h77, 1'b0, 8'h00, 1'b1, 1'b0, 2'b01, 8'h77, 1'b0);
    n = 0;
    while (!err_timeout && n < 200) begin cyc(1); n++; end
    chk("timeout_latency", n, 64);
    chk("timeout_grant", grant, 2'b00);
    cyc(1);
    chk("timeout_pulse_width", err_timeout, 0);
    cyc(3);
    mode = 0;
    serve(1'b0, 8'h00, 1'b1, 8'h4B, 1'b0, 1'b1, 2'b10, 8'h4B, 1'b1);

    // Foreign activity on the transmitter blocks grants.
    mode = 2; force_busy = 1'b1;
    @(negedge clk);
    req0_valid = 1'b1; req0_data = 8'h5E;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (req0_ready || req1_ready) n++;
    end
    chk("no_ready_while_busy", n, 0);
    force_busy = 1'b0; mode = 0;
    serve(1'b1, 8'h5E, 1'b0, 8'h00, 1'b1, 1'b0, 2'b01, 8'h5E, 1'b1);

    // Asynchronous reset while the frame is on the line.
    serve(1'b0, 8'h00, 1'b1, 8'h99, 1'b0, 1'b1, 2'b10, 8'h99, 1'b0);
    n = 0;
    while (!tx_busy && n < 50) begin cyc(1); n++; end
    chk("busy_before_reset", tx_busy, 1);
    cyc(5);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_grant", grant, 2'b00);
    chk("midreset_tx_int", tx_int, 0);
    chk("midreset_tx_data", tx_data, 8'h00);
    chk("midreset_err", err_timeout, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    serve(1'b1, 8'h3C, 1'b0, 8'h00, 1'b1, 1'b0, 2'b01, 8'h3C, 1'b1);

    cyc(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1);
  end

endmodule
